// File: rtl/memory_access.sv
// ============================================================================
// Module   : memory_access
// Brief    : Pipeline memory stage. Issues byte-lane data-memory requests for
//            loads/stores and registers results for write-back. Optional
//            feature macro: MISALIGN_CHECK_EN (rejects misaligned LH/LHU/SH
//            and LW/SW).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif

module memory_access #(
  parameter AWIDTH      = 5,
  parameter DWIDTH      = 32,
  parameter FUNCT_WIDTH = 3,
  parameter PC_WIDTH    = 32
) (
  input  logic                     me_clk,
  input  logic                     me_rst,
  input  logic [`OPCODE_WIDTH-1:0] me_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]   me_i_funct3,
  input  logic [DWIDTH-1:0]        me_i_alu_value,
  input  logic [DWIDTH-1:0]        me_i_data_rs2,
  input  logic [DWIDTH-1:0]        me_i_data_rd,
  input  logic [AWIDTH-1:0]        me_i_addr_rd,
  input  logic                     me_i_we_reg,
  input  logic [PC_WIDTH-1:0]      me_i_pc,
  input  logic                     me_i_ce,
  input  logic                     me_i_flush,
  input  logic                     me_i_stall,
  output logic                     me_o_stall,
  output logic                     me_o_ce,
  output logic                     me_o_we_reg,
  output logic [DWIDTH-1:0]        me_o_data_rd,
  output logic [AWIDTH-1:0]        me_o_addr_rd,
  output logic [`OPCODE_WIDTH-1:0] me_o_opcode,
  output logic [FUNCT_WIDTH-1:0]   me_o_funct3,
  output logic [PC_WIDTH-1:0]      me_o_pc,
  output logic                     me_o_req,
  output logic                     me_o_we,
  output logic [DWIDTH-1:0]        me_o_addr,
  output logic [DWIDTH-1:0]        me_o_wdata,
  output logic [3:0]               me_o_byte_en,
  input  logic                     me_i_ack,
  input  logic [DWIDTH-1:0]        me_i_rdata,
  output logic                     me_o_misaligned
);

  localparam logic [`OPCODE_WIDTH-1:0] c_LOAD_WORD  = `OPCODE_WIDTH'(7'b0000011);
  localparam logic [`OPCODE_WIDTH-1:0] c_STORE_WORD = `OPCODE_WIDTH'(7'b0100011);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic                     r_ce, r_we_reg, r_req, r_we, r_misaligned, r_flushed;
  logic [DWIDTH-1:0]        r_data_rd, r_addr, r_wdata;
  logic [AWIDTH-1:0]        r_addr_rd;
  logic [`OPCODE_WIDTH-1:0] r_opcode;
  logic [FUNCT_WIDTH-1:0]   r_funct3;
  logic [PC_WIDTH-1:0]      r_pc;
  logic [3:0]               r_byte_en;
  logic [1:0]               r_addr_lo;

  logic              w_accept, w_is_load, w_is_store, w_is_mem, w_misalign;
  logic [3:0]        w_byte_en;
  logic [DWIDTH-1:0] w_wdata, w_load_data;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_flush_eff;

  assign w_accept    = me_i_ce && !me_i_flush && !me_i_stall && (r_state == S_IDLE);
  assign w_is_load   = (me_i_opcode == c_LOAD_WORD);
  assign w_is_store  = (me_i_opcode == c_STORE_WORD);
  assign w_is_mem    = w_is_load || w_is_store;
  assign w_flush_eff = r_flushed || me_i_flush;

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = w_is_mem &&
                      (((me_i_funct3[1:0] == 2'b01) && me_i_alu_value[0]) ||
                       ((me_i_funct3[1:0] == 2'b10) && (me_i_alu_value[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Store lanes; loads always fetch the whole word and extract on return.
  always_comb begin
    w_byte_en = 4'b1111;
    w_wdata   = me_i_data_rs2;
    if (w_is_store) begin
      case (me_i_funct3[1:0])
        2'b00: begin
          w_byte_en = 4'b0001 << me_i_alu_value[1:0];
          w_wdata   = {4{me_i_data_rs2[7:0]}};
        end
        2'b01: begin
          w_byte_en = 4'b0011 << {me_i_alu_value[1], 1'b0};
          w_wdata   = {2{me_i_data_rs2[15:0]}};
        end
        default: begin
          w_byte_en = 4'b1111;
          w_wdata   = me_i_data_rs2;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = me_i_rdata[7:0];
    case (r_addr_lo)
      2'd0:    w_byte = me_i_rdata[7:0];
      2'd1:    w_byte = me_i_rdata[15:8];
      2'd2:    w_byte = me_i_rdata[23:16];
      default: w_byte = me_i_rdata[31:24];
    endcase
    w_half = r_addr_lo[1] ? me_i_rdata[31:16] : me_i_rdata[15:0];
    case (r_funct3[2:0])
      3'b000:  w_load_data = {{(DWIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(DWIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(DWIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(DWIDTH-16){1'b0}}, w_half};
      default: w_load_data = me_i_rdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mem && !w_misalign) w_state_next = S_REQ;
      S_REQ:   if (me_i_ack) w_state_next = S_DONE;
      S_DONE:  if (!me_i_stall) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge me_clk or negedge me_rst) begin
    if (!me_rst) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge me_clk or negedge me_rst) begin
    if (!me_rst) begin
      r_ce         <= 1'b0;
      r_we_reg     <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_misaligned <= 1'b0;
      r_flushed    <= 1'b0;
      r_data_rd    <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_addr_rd    <= '0;
      r_opcode     <= '0;
      r_funct3     <= '0;
      r_pc         <= '0;
      r_byte_en    <= '0;
      r_addr_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_opcode     <= me_i_opcode;
            r_funct3     <= me_i_funct3;
            r_pc         <= me_i_pc;
            r_addr_rd    <= me_i_addr_rd;
            r_data_rd    <= me_i_data_rd;
            r_addr_lo    <= me_i_alu_value[1:0];
            r_misaligned <= w_misalign;
            r_flushed    <= 1'b0;
            if (w_is_mem && !w_misalign) begin
              r_req     <= 1'b1;
              r_we      <= w_is_store;
              r_addr    <= {me_i_alu_value[DWIDTH-1:2], 2'b00};
              r_byte_en <= w_byte_en;
              r_wdata   <= w_wdata;
              r_ce      <= 1'b0;
              r_we_reg  <= 1'b0;
            end else begin
              r_ce     <= 1'b1;
              r_we_reg <= w_misalign ? 1'b0 : me_i_we_reg;
            end
          end else if (!me_i_stall) begin
            r_ce         <= 1'b0;
            r_we_reg     <= 1'b0;
            r_misaligned <= 1'b0;
          end
        end
        S_REQ: begin
          // Result is written at the ack edge: me_o_ce was cleared on accept,
          // so nothing downstream is holding a value from this stage yet.
          if (me_i_ack) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_ce     <= !w_flush_eff;
            r_we_reg <= (r_opcode == c_LOAD_WORD) && (r_addr_rd != '0) && !w_flush_eff;
            if (r_opcode == c_LOAD_WORD) r_data_rd <= w_load_data;
          end else if (me_i_flush) begin
            r_flushed <= 1'b1;
          end
        end
        S_DONE: begin
          if (!me_i_stall) begin
            r_ce     <= 1'b0;
            r_we_reg <= 1'b0;
          end
        end
        default: begin
          r_req <= 1'b0;
          r_we  <= 1'b0;
        end
      endcase
    end
  end

  assign me_o_stall      = (r_state != S_IDLE);
  assign me_o_ce         = r_ce;
  assign me_o_we_reg     = r_we_reg;
  assign me_o_data_rd    = r_data_rd;
  assign me_o_addr_rd    = r_addr_rd;
  assign me_o_opcode     = r_opcode;
  assign me_o_funct3     = r_funct3;
  assign me_o_pc         = r_pc;
  assign me_o_req        = r_req;
  assign me_o_we         = r_we;
  assign me_o_addr       = r_addr;
  assign me_o_wdata      = r_wdata;
  assign me_o_byte_en    = r_byte_en;
  assign me_o_misaligned = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// ============================================================================
// Module   : tb_memory_access
// Brief    : Directed vector bench for memory_access (honours MISALIGN_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_access;

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_ADD   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu, rs2, data_rd, pc, rdata;
  logic [4:0]  addr_rd;
  logic        we_reg, ce, flush, stall, ack;
  logic        o_stall, o_ce, o_we_reg, o_req, o_we, o_mis;
  logic [31:0] o_data_rd, o_pc, o_addr, o_wdata;
  logic [4:0]  o_addr_rd;
  logic [6:0]  o_opcode;
  logic [2:0]  o_funct3;
  logic [3:0]  o_be;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .me_clk(clk), .me_rst(rst_n),
    .me_i_opcode(opcode), .me_i_funct3(funct3), .me_i_alu_value(alu),
    .me_i_data_rs2(rs2), .me_i_data_rd(data_rd), .me_i_addr_rd(addr_rd),
    .me_i_we_reg(we_reg), .me_i_pc(pc), .me_i_ce(ce), .me_i_flush(flush),
    .me_i_stall(stall), .me_o_stall(o_stall), .me_o_ce(o_ce),
    .me_o_we_reg(o_we_reg), .me_o_data_rd(o_data_rd), .me_o_addr_rd(o_addr_rd),
    .me_o_opcode(o_opcode), .me_o_funct3(o_funct3), .me_o_pc(o_pc),
    .me_o_req(o_req), .me_o_we(o_we), .me_o_addr(o_addr), .me_o_wdata(o_wdata),
    .me_o_byte_en(o_be), .me_i_ack(ack), .me_i_rdata(rdata),
    .me_o_misaligned(o_mis)
  );

  // kind: 0 = non-memory, 1 = bus access, 2 = rejected as misaligned
  typedef struct {
    int          kind;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] alu, rs2, drd;
    logic [4:0]  ard;
    logic        wer;
    int          waits;
    logic [31:0] rdata, e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_we_reg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int kind, logic [6:0] op, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] r2, logic [31:0] drd,
                              logic [4:0] ard, logic wer, int waits,
                              logic [31:0] rd, logic [31:0] ea, logic [3:0] ebe,
                              logic [31:0] ewd, logic ewe, logic [31:0] edata,
                              logic ewer);
    vec_t v;
    v.kind = kind; v.op = op; v.f3 = f3; v.alu = a; v.rs2 = r2; v.drd = drd;
    v.ard = ard; v.wer = wer; v.waits = waits; v.rdata = rd; v.e_addr = ea;
    v.e_be = ebe; v.e_wdata = ewd; v.e_we = ewe; v.e_data = edata; v.e_we_reg = ewer;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; funct3 = v.f3; alu = v.alu; rs2 = v.rs2; data_rd = v.drd;
    addr_rd = v.ard; we_reg = v.wer; pc = v.alu + 32'h4000; ce = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk); #1;
    ce = 1'b0;
    case (v.kind)
      0: begin
        chk("alu_ce",      32'(o_ce), 32'd1);
        chk("alu_data",    o_data_rd, v.e_data);
        chk("alu_we_reg",  32'(o_we_reg), 32'(v.e_we_reg));
        chk("alu_addr_rd", 32'(o_addr_rd), 32'(v.ard));
        chk("alu_pc",      o_pc, v.alu + 32'h4000);
        chk("alu_req",     32'(o_req), 32'd0);
        chk("alu_stall",   32'(o_stall), 32'd0);
        @(posedge clk); #1;
        chk("alu_ce_drop", 32'(o_ce), 32'd0);
      end
      2: begin
        chk("mis_ce",     32'(o_ce), 32'd1);
        chk("mis_flag",   32'(o_mis), 32'd1);
        chk("mis_we_reg", 32'(o_we_reg), 32'd0);
        chk("mis_req",    32'(o_req), 32'd0);
        chk("mis_stall",  32'(o_stall), 32'd0);
        @(posedge clk); #1;
        chk("mis_drop",   32'(o_mis), 32'd0);
        chk("mis_req2",   32'(o_req), 32'd0);
      end
      default: begin
        chk("req",     32'(o_req), 32'd1);
        chk("addr",    o_addr, v.e_addr);
        chk("byte_en", 32'(o_be), 32'(v.e_be));
        chk("wdata",   o_wdata, v.e_wdata);
        chk("we",      32'(o_we), 32'(v.e_we));
        chk("stall",   32'(o_stall), 32'd1);
        for (int i = 0; i < v.waits; i++) begin
          @(posedge clk); #1;
          chk("req_hold",   32'(o_req), 32'd1);
          chk("addr_hold",  o_addr, v.e_addr);
          chk("stall_hold", 32'(o_stall), 32'd1);
          chk("ce_wait",    32'(o_ce), 32'd0);
        end
        ack = 1'b1; rdata = v.rdata;
        @(posedge clk); #1;
        ack = 1'b0; rdata = 32'h0;
        chk("req_drop",   32'(o_req), 32'd0);
        chk("done_ce",    32'(o_ce), 32'd1);
        chk("done_data",  o_data_rd, v.e_data);
        chk("done_we_rg", 32'(o_we_reg), 32'(v.e_we_reg));
        chk("done_pc",    o_pc, v.alu + 32'h4000);
        @(posedge clk); #1;
        chk("idle_ce",    32'(o_ce), 32'd0);
        chk("idle_stall", 32'(o_stall), 32'd0);
      end
    endcase
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; alu = '0; rs2 = '0; data_rd = '0;
    pc = '0; rdata = '0; addr_rd = '0; we_reg = 1'b0; ce = 1'b0; flush = 1'b0;
    stall = 1'b0; ack = 1'b0;

    vecs.push_back(mk(0, c_OP_ADD, 3'd0, 32'h10, 0, 32'h12345678, 5'd5, 1, 0, 0, 0, 0, 0, 0, 32'h12345678, 1));
    vecs.push_back(mk(0, c_OP_ADD, 3'd0, 32'h20, 0, 32'h0BADF00D, 5'd9, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D, 0));
    vecs.push_back(mk(1, c_OP_STORE, 3'd2, 32'h100, 32'hDEADBEEF, 0, 5'd0, 0, 2, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 1, 0, 0));
    vecs.push_back(mk(1, c_OP_LOAD, 3'd0, 32'h203, 0, 0, 5'd7, 0, 0, 32'h80000000, 32'h200, 4'b1111, 0, 0, 32'hFFFFFF80, 1));
    vecs.push_back(mk(1, c_OP_STORE, 3'd1, 32'h42, 32'h1234ABCD, 0, 5'd0, 0, 0, 0, 32'h40, 4'b1100, 32'hABCDABCD, 1, 0, 0));
    vecs.push_back(mk(1, c_OP_STORE, 3'd0, 32'h101, 32'h000000A5, 0, 5'd0, 0, 1, 0, 32'h100, 4'b0010, 32'hA5A5A5A5, 1, 0, 0));
    vecs.push_back(mk(1, c_OP_LOAD, 3'd5, 32'h302, 0, 0, 5'd4, 0, 1, 32'hBEEF1234, 32'h300, 4'b1111, 0, 0, 32'h0000BEEF, 1));
    vecs.push_back(mk(1, c_OP_LOAD, 3'd1, 32'h300, 0, 0, 5'd0, 0, 0, 32'h0000F00D, 32'h300, 4'b1111, 0, 0, 32'hFFFFF00D, 0));
    vecs.push_back(mk(1, c_OP_LOAD, 3'd4, 32'h401, 0, 0, 5'd2, 0, 3, 32'h11223344, 32'h400, 4'b1111, 0, 0, 32'h00000033, 1));
    vecs.push_back(mk(1, c_OP_LOAD, 3'd2, 32'h500, 0, 0, 5'd31, 0, 0, 32'hCAFEF00D, 32'h500, 4'b1111, 0, 0, 32'hCAFEF00D, 1));
`ifdef MISALIGN_CHECK_EN
    vecs.push_back(mk(2, c_OP_LOAD, 3'd2, 32'h102, 0, 0, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, c_OP_STORE, 3'd1, 32'h43, 32'h0000BEEF, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, c_OP_STORE, 3'd2, 32'h106, 32'h01020304, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
    vecs.push_back(mk(1, c_OP_LOAD, 3'd2, 32'h102, 0, 0, 5'd3, 0, 0, 32'h55AA55AA, 32'h100, 4'b1111, 0, 0, 32'h55AA55AA, 1));
    vecs.push_back(mk(1, c_OP_STORE, 3'd1, 32'h43, 32'h0000BEEF, 0, 5'd0, 0, 0, 0, 32'h40, 4'b1100, 32'hBEEFBEEF, 1, 0, 0));
    vecs.push_back(mk(1, c_OP_STORE, 3'd2, 32'h106, 32'h01020304, 0, 5'd0, 0, 0, 0, 32'h104, 4'b1111, 32'h01020304, 1, 0, 0));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",  32'(o_req), 32'd0);
    chk("rst_ce",   32'(o_ce), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    chk("rst_be",   32'(o_be), 32'd0);
    chk("rst_data", o_data_rd, 32'd0);
    chk("rst_mis",  32'(o_mis), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Ack with no request outstanding is ignored
    @(negedge clk); ack = 1'b1; rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; ack = 1'b0; rdata = 32'h0;
    chk("stray_req",   32'(o_req), 32'd0);
    chk("stray_ce",    32'(o_ce), 32'd0);
    chk("stray_stall", 32'(o_stall), 32'd0);

    // Flush while a load waits: access completes, result suppressed
    @(negedge clk);
    drive(mk(1, c_OP_LOAD, 3'd2, 32'h600, 0, 0, 5'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; ce = 1'b0; flush = 1'b1;
    chk("fl_req", 32'(o_req), 32'd1);
    @(posedge clk); #1; flush = 1'b0; ack = 1'b1; rdata = 32'h12345678;
    chk("fl_req_hold", 32'(o_req), 32'd1);
    @(posedge clk); #1; ack = 1'b0; rdata = 32'h0;
    chk("fl_req_drop", 32'(o_req), 32'd0);
    chk("fl_ce",       32'(o_ce), 32'd0);
    chk("fl_we_reg",   32'(o_we_reg), 32'd0);
    @(posedge clk); #1;
    chk("fl_stall", 32'(o_stall), 32'd0);

    // Downstream stall holds a non-memory result
    @(negedge clk);
    drive(mk(0, c_OP_ADD, 3'd0, 32'h30, 0, 32'h00C0FFEE, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; ce = 1'b0; stall = 1'b1;
    chk("st_ce", 32'(o_ce), 32'd1);
    @(posedge clk); #1;
    chk("st_ce_hold",   32'(o_ce), 32'd1);
    chk("st_data_hold", o_data_rd, 32'h00C0FFEE);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("st_ce_drop", 32'(o_ce), 32'd0);

    // Downstream stall delays DONE -> IDLE
    @(negedge clk);
    drive(mk(1, c_OP_LOAD, 3'd2, 32'h700, 0, 0, 5'd10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; ce = 1'b0; ack = 1'b1; rdata = 32'hA5A50F0F; stall = 1'b1;
    @(posedge clk); #1; ack = 1'b0; rdata = 32'h0;
    chk("sd_ce",   32'(o_ce), 32'd1);
    chk("sd_data", o_data_rd, 32'hA5A50F0F);
    @(posedge clk); #1;
    chk("sd_ce_hold",    32'(o_ce), 32'd1);
    chk("sd_stall_hold", 32'(o_stall), 32'd1);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("sd_ce_drop",   32'(o_ce), 32'd0);
    chk("sd_stall_drop", 32'(o_stall), 32'd0);

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    drive(mk(1, c_OP_LOAD, 3'd2, 32'h800, 0, 0, 5'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; ce = 1'b0;
    chk("ar_req", 32'(o_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req_drop", 32'(o_req), 32'd0);
    chk("ar_stall",    32'(o_stall), 32'd0);
    chk("ar_be",       32'(o_be), 32'd0);
    chk("ar_addr",     o_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_vec(mk(0, c_OP_ADD, 3'd0, 32'h40, 0, 32'h00000042, 5'd12, 1, 0, 0, 0, 0, 0, 0, 32'h00000042, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
